// File: rtl/debug_dma_ctrl.sv
// Per-thread context sequencer for the debug/initialization DMA engine.
// Holds {addr, buf_addr, count, op} per thread, serves fetch lookups and applies commit feedback.
module debug_dma_ctrl #(
   parameter int NTHREAD   = 64,
   parameter int DMABUFMSB = 9,
   localparam int TW = $clog2(NTHREAD),
   localparam int BW = DMABUFMSB + 1
) (
   input  logic          gclk,
   input  logic          rstn,
   input  logic [TW-1:0] cmd_tid,
   input  logic          cmd_addr_we,
   input  logic [29:0]   cmd_addr,
   input  logic          cmd_addr_par,
   input  logic          cmd_ctrl_we,
   input  logic [BW-1:0] cmd_buf_addr,
   input  logic [BW-1:0] cmd_count,
   input  logic          cmd_op,
   input  logic          cmd_ctrl_par,
   input  logic [TW-1:0] if_tid,
   output logic          if_op,
   output logic [29:0]   if_addr,
   output logic [BW-1:0] if_buf_addr,
   output logic [BW-1:0] if_count,
   input  logic          com_valid,
   input  logic [TW-1:0] com_tid,
   input  logic          com_ack,
   input  logic          com_done,
   output logic          done_pulse,
   output logic [TW-1:0] done_tid,
   output logic [TW:0]   active_cnt,
   output logic          par_err,
   output logic [TW-1:0] par_err_tid,
   input  logic          par_err_clr
);

   logic [NTHREAD-1:0][29:0]   addr_tab;
   logic [NTHREAD-1:0][BW-1:0] buf_tab;
   logic [NTHREAD-1:0][BW-1:0] cnt_tab;
   logic [NTHREAD-1:0]         op_tab;

   logic addr_bad, ctrl_bad, addr_ok, ctrl_ok, any_err;
   logic com_apply, com_zero, retire, same_tid, retire_eff;
   logic act_inc, act_dec_cmd, act_dec_com;

   assign addr_bad = cmd_addr_we & (^{cmd_addr, cmd_addr_par});
   assign ctrl_bad = cmd_ctrl_we & (^{cmd_buf_addr, cmd_count, cmd_op, cmd_ctrl_par});
   assign addr_ok  = cmd_addr_we & ~addr_bad;
   assign ctrl_ok  = cmd_ctrl_we & ~ctrl_bad;
   assign any_err  = addr_bad | ctrl_bad;

   assign com_apply  = com_valid & op_tab[com_tid];
   assign com_zero   = (cnt_tab[com_tid] == '0);
   assign retire     = com_apply & (com_done | (com_ack & com_zero));
   assign same_tid   = ctrl_ok & (cmd_tid == com_tid);
   // A ctrl write re-arming the same thread cancels its retirement
   assign retire_eff = retire & ~(same_tid & cmd_op);

   // Same-tid collisions are accounted on the command side, which sets the final op
   assign act_inc     = ctrl_ok & ~op_tab[cmd_tid] & cmd_op;
   assign act_dec_cmd = ctrl_ok & op_tab[cmd_tid] & ~cmd_op;
   assign act_dec_com = retire_eff & ~same_tid;

   // Context table: commit first, command writes override the fields they touch
   always_ff @(posedge gclk or negedge rstn) begin
      if (!rstn) begin
         addr_tab <= '0;
         buf_tab  <= '0;
         cnt_tab  <= '0;
         op_tab   <= '0;
      end else begin
         if (com_apply && com_ack) begin
            addr_tab[com_tid] <= addr_tab[com_tid] + 30'd1;
            buf_tab[com_tid]  <= buf_tab[com_tid] + BW'(1);
            if (!com_zero)
               cnt_tab[com_tid] <= cnt_tab[com_tid] - BW'(1);
         end
         if (retire)
            op_tab[com_tid] <= 1'b0;
         if (addr_ok)
            addr_tab[cmd_tid] <= cmd_addr;
         if (ctrl_ok) begin
            buf_tab[cmd_tid] <= cmd_buf_addr;
            cnt_tab[cmd_tid] <= cmd_count;
            op_tab[cmd_tid]  <= cmd_op;
         end
      end
   end

   // Fetch lookup, retirement pulse, occupancy and parity status
   always_ff @(posedge gclk or negedge rstn) begin
      if (!rstn) begin
         if_op       <= 1'b0;
         if_addr     <= '0;
         if_buf_addr <= '0;
         if_count    <= '0;
         done_pulse  <= 1'b0;
         done_tid    <= '0;
         active_cnt  <= '0;
         par_err     <= 1'b0;
         par_err_tid <= '0;
      end else begin
         if_op       <= op_tab[if_tid];
         if_addr     <= addr_tab[if_tid];
         if_buf_addr <= buf_tab[if_tid];
         if_count    <= cnt_tab[if_tid];
         done_pulse  <= retire_eff;
         if (retire_eff)
            done_tid <= com_tid;
         active_cnt <= active_cnt + (TW+1)'(act_inc) - (TW+1)'(act_dec_cmd)
                       - (TW+1)'(act_dec_com);
         if (any_err && !par_err)
            par_err_tid <= cmd_tid;
         if (any_err)
            par_err <= 1'b1;
         else if (par_err_clr)
            par_err <= 1'b0;
      end
   end

endmodule

// File: doc/debug_dma_ctrl.md
# debug_dma_ctrl

Per-thread sequencer for the on-chip debug/initialization DMA engine. It holds one DMA context per hardware thread: word address, buffer address, remaining count and command. The host command interface programs these contexts. At instruction fetch, the block supplies each thread's context to the IU so the engine can inject LD/ST instructions. At the end of the xc/com stage, it takes the IU's ack/done feedback, advances the context and retires it. It sits between the debug command interface, the fetch stage and the commit stage, and owns all DMA progress state.

## Interface
- NTHREAD, 64: hardware threads. Thread-ID width TW = log2(NTHREAD).
- DMABUFMSB, 9: buffer address and count MSB, giving a 1024-word buffer.
- gclk  in  1  pipeline clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- cmd_tid  in  TW  thread targeted by a command write.
- cmd_addr_we  in  1  write the address register.
- cmd_addr  in  30  word-aligned virtual address.
- cmd_addr_par  in  1  even parity bit over cmd_addr.
- cmd_ctrl_we  in  1  write the control register.
- cmd_buf_addr  in  DMABUFMSB+1  starting buffer word.
- cmd_count  in  DMABUFMSB+1  transfers minus one.
- cmd_op  in  1  0 = dma_NOP, 1 = dma_OP.
- cmd_ctrl_par  in  1  even parity bit over {cmd_buf_addr, cmd_count, cmd_op}.
- if_tid  in  TW  thread in fetch.
- if_op, if_addr, if_buf_addr, if_count  out  1/30/10/10  context of if_tid, registered.
- com_valid  in  1  commit-stage feedback valid.
- com_tid  in  TW  thread at commit.
- com_ack  in  1  one word transferred.
- com_done  in  1  transaction aborted or complete.
- done_pulse  out  1  one-cycle pulse when a context retires.
- done_tid  out  TW  thread of that retirement.
- active_cnt  out  TW+1  number of contexts with op = dma_OP.
- par_err  out  1  sticky parity error flag.
- par_err_tid  out  TW  thread of the first parity error.
- par_err_clr  in  1  clears par_err.

## Operation
- Context table: NTHREAD entries of {addr[29:0], buf_addr, count, op}. Written only at the gclk edge.
- Command write, addr: if ^{cmd_addr, cmd_addr_par} == 0, then addr[cmd_tid] <= cmd_addr. Otherwise the write is dropped.
- Command write, ctrl: if ^{cmd_buf_addr, cmd_count, cmd_op, cmd_ctrl_par} == 0, then buf_addr, count and op of cmd_tid are loaded. Otherwise the write is dropped.
- Parity error: a dropped write sets par_err. par_err_tid is captured only when par_err was 0. An addr and a ctrl error in the same cycle count as one error, same tid. par_err_clr clears par_err; if an error occurs in the same cycle as par_err_clr, the error wins.
- Commit feedback applies only when com_valid = 1 and op[com_tid] = dma_OP. Otherwise it is ignored.
  - com_ack with count != 0: addr += 1 (mod 2^30), buf_addr += 1 (mod 1024), count -= 1.
  - com_ack with count == 0: op <= dma_NOP; addr and buf_addr still increment; done_pulse fires.
  - com_done, with or without ack: op <= dma_NOP; done_pulse fires. The ack increments still apply if com_ack = 1.
- Collision: a command write and commit feedback to the same tid in the same cycle. The command wins for the fields it writes. An addr-only write still lets op/count/buf_addr update from commit. A retirement overridden by a ctrl write with op = 1 produces no done_pulse.
- active_cnt: +1 for each NOP→OP transition, -1 for each OP→NOP transition. It never wraps because its range is 0..NTHREAD.

## Timing
- Fetch lookup: 1-cycle latency. if_* at edge N+1 shows table contents as of edge N, before edge N's updates. There is no bypass. The interleaved pipeline guarantees if_tid != com_tid in the same cycle; cmd vs if collisions read the old value.
- done_pulse/done_tid: registered, asserted the cycle after the retiring edge, one cycle wide. Back-to-back retirements of different tids produce consecutive pulses.
- Command and commit effects are visible to fetch two edges later.
- Reset (rstn = 0, asynchronous):
  - all table entries go to 0 with op = dma_NOP;
  - if_* = 0, done_pulse = 0, done_tid = 0, active_cnt = 0, par_err = 0, par_err_tid = 0.
  - Deassertion is synchronous to gclk through an external synchronizer.
- Reset mid-transfer discards all contexts with no done_pulse.

## Test plan
- Reset, then sweep if_tid over 0..NTHREAD-1 → every if_op = 0 and if_addr = 0; active_cnt = 0.
- tid 5: addr = 0x100, buf = 0x3FE, count = 2, op = 1; then three com_ack cycles on tid 5 → addr 0x101/0x102/0x103, buf 0x3FF/0x000/0x001, done_pulse once with done_tid = 5 after the third ack; active_cnt goes 0→1→0.
- ctrl write to tid 3 with a flipped cmd_ctrl_par → tid 3 unchanged, par_err = 1, par_err_tid = 3. A later bad write to tid 7 keeps par_err_tid = 3. par_err_clr → 0.
- tid 9 running with count = 7, com_done without ack → op = 0, count stays 7, done_pulse.
- Same-cycle ctrl write (op = 1, count = 4) and final com_ack on tid 2 → op stays 1, count = 4, no done_pulse, active_cnt unchanged.
- rstn low mid-transfer on tid 1 → all outputs 0 immediately (asynchronously); no done_pulse after release.
